// File: rtl/key_event_gen_if.sv
// key_event_gen_if: valid/ready key event stream between key_event_gen and its consumer.
interface key_event_gen_if #(
  parameter int unsigned KEY_W = 3
);
  logic             event_valid;
  logic             event_ready;
  logic [KEY_W-1:0] event_key;
  logic [1:0]       event_type;

  modport master (output event_valid, event_key, event_type, input event_ready);
  modport slave  (input event_valid, event_key, event_type, output event_ready);
endinterface

// File: rtl/key_event_gen.sv
// key_event_gen: turns debounced key levels into PRESS/RELEASE/LONG/REPEAT events via a small FIFO.
// Define KEY_EVENT_REPEAT_EN to build the auto-repeat (REPEAT) event path.
module key_event_gen #(
  parameter int unsigned NUM_KEYS         = 8,
  parameter int unsigned LONG_PRESS_TICKS = 500,
  parameter int unsigned REPEAT_TICKS     = 100,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic [NUM_KEYS-1:0] key_in,
  key_event_gen_if.master     ev,
  output logic                overflow,
  input  logic                overflow_clear
);
  localparam int unsigned KEY_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int unsigned CNT_MAX = (LONG_PRESS_TICKS > REPEAT_TICKS) ? LONG_PRESS_TICKS : REPEAT_TICKS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W  = PTR_W + 1;
  localparam int unsigned SLOTS   = 4 * NUM_KEYS;
  localparam int unsigned SLOT_W  = $clog2(SLOTS);

  localparam logic [1:0] T_PRESS   = 2'd0;
  localparam logic [1:0] T_RELEASE = 2'd1;
  localparam logic [1:0] T_LONG    = 2'd2;
  localparam logic [1:0] T_REPEAT  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} key_state_e;
  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [1:0]       kind;
  } event_t;

  key_state_e          state [NUM_KEYS];
  logic [CNT_W-1:0]    cnt   [NUM_KEYS];
  logic [NUM_KEYS-1:0] key_prev;
  logic [NUM_KEYS-1:0] pend_press, pend_long, pend_release;
  logic [NUM_KEYS-1:0] fire_press, fire_long, fire_release;
  logic [NUM_KEYS-1:0] gnt_press, gnt_long, gnt_release;
  logic [NUM_KEYS-1:0] drop_vec;
`ifdef KEY_EVENT_REPEAT_EN
  logic [NUM_KEYS-1:0] pend_repeat, fire_repeat, gnt_repeat;
`endif

  logic [SLOTS-1:0]  slots;
  logic              gnt_valid;
  logic [SLOT_W-1:0] gnt_idx;
  logic              push, pop, full, head_from_push;
  event_t            push_ev;
  event_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_next;
  logic [FCNT_W-1:0] fcnt, fcnt_next;

  // Per-key event detection; release always beats a coincident threshold tick.
  always_comb begin
    fire_press   = '0;
    fire_long    = '0;
    fire_release = '0;
`ifdef KEY_EVENT_REPEAT_EN
    fire_repeat  = '0;
`endif
    for (int k = 0; k < NUM_KEYS; k++) begin
      fire_press[k]   = (state[k] == S_IDLE) && key_in[k] && !key_prev[k];
      fire_release[k] = (state[k] != S_IDLE) && !key_in[k];
      fire_long[k]    = (state[k] == S_PRESSED) && key_in[k] && tick &&
                        (cnt[k] == CNT_W'(LONG_PRESS_TICKS - 1));
`ifdef KEY_EVENT_REPEAT_EN
      fire_repeat[k]  = (state[k] == S_HELD) && key_in[k] && tick &&
                        (cnt[k] == CNT_W'(REPEAT_TICKS - 1));
`endif
    end
  end

  // Fixed-priority arbiter over {key, PRESS, LONG, REPEAT, RELEASE} slots, lowest index wins.
  always_comb begin
    slots     = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      slots[4*k]   = pend_press[k];
      slots[4*k+1] = pend_long[k];
`ifdef KEY_EVENT_REPEAT_EN
      slots[4*k+2] = pend_repeat[k];
`endif
      slots[4*k+3] = pend_release[k];
    end
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (slots[i]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SLOT_W'(i);
      end
    end
  end

  assign pop  = ev.event_valid & ev.event_ready;
  assign full = (fcnt == FCNT_W'(FIFO_DEPTH));
  assign push = gnt_valid & (~full | pop);

  always_comb begin
    push_ev.key = KEY_W'(gnt_idx >> 2);
    unique case (gnt_idx[1:0])
      2'd0:    push_ev.kind = T_PRESS;
      2'd1:    push_ev.kind = T_LONG;
      2'd2:    push_ev.kind = T_REPEAT;
      default: push_ev.kind = T_RELEASE;
    endcase
    gnt_press   = '0;
    gnt_long    = '0;
    gnt_release = '0;
`ifdef KEY_EVENT_REPEAT_EN
    gnt_repeat  = '0;
`endif
    for (int k = 0; k < NUM_KEYS; k++) begin
      gnt_press[k]   = push && (gnt_idx == SLOT_W'(4*k));
      gnt_long[k]    = push && (gnt_idx == SLOT_W'(4*k+1));
`ifdef KEY_EVENT_REPEAT_EN
      gnt_repeat[k]  = push && (gnt_idx == SLOT_W'(4*k+2));
`endif
      gnt_release[k] = push && (gnt_idx == SLOT_W'(4*k+3));
    end
    // A pending bit being pushed this cycle frees room for a new event of that type.
    drop_vec = (fire_press & pend_press & ~gnt_press) |
               (fire_long & pend_long & ~gnt_long) |
               (fire_release & pend_release & ~gnt_release);
`ifdef KEY_EVENT_REPEAT_EN
    drop_vec = drop_vec | (fire_repeat & pend_repeat & ~gnt_repeat);
`endif
  end

  assign fcnt_next      = fcnt + FCNT_W'(push) - FCNT_W'(pop);
  assign rd_next        = rd_ptr + PTR_W'(pop);
  assign head_from_push = push && (fcnt == FCNT_W'(pop));

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_ev;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        state[k] <= S_IDLE;
        cnt[k]   <= '0;
      end
      key_prev       <= '0;
      pend_press     <= '0;
      pend_long      <= '0;
      pend_release   <= '0;
`ifdef KEY_EVENT_REPEAT_EN
      pend_repeat    <= '0;
`endif
      overflow       <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      fcnt           <= '0;
      ev.event_valid <= 1'b0;
      ev.event_key   <= '0;
      ev.event_type  <= '0;
    end else begin
      key_prev <= key_in;
      for (int k = 0; k < NUM_KEYS; k++) begin
        unique case (state[k])
          S_IDLE: begin
            if (fire_press[k]) begin
              state[k] <= S_PRESSED;
              cnt[k]   <= '0;
            end
          end
          S_PRESSED: begin
            if (!key_in[k]) begin
              state[k] <= S_IDLE;
            end else if (fire_long[k]) begin
              state[k] <= S_HELD;
              cnt[k]   <= '0;
            end else if (tick) begin
              cnt[k] <= cnt[k] + CNT_W'(1);
            end
          end
          S_HELD: begin
            if (!key_in[k]) begin
              state[k] <= S_IDLE;
`ifdef KEY_EVENT_REPEAT_EN
            end else if (fire_repeat[k]) begin
              cnt[k] <= '0;
            end else if (tick) begin
              cnt[k] <= cnt[k] + CNT_W'(1);
`endif
            end
          end
          default: state[k] <= S_IDLE;
        endcase
      end
      pend_press   <= (pend_press & ~gnt_press) | fire_press;
      pend_long    <= (pend_long & ~gnt_long) | fire_long;
      pend_release <= (pend_release & ~gnt_release) | fire_release;
`ifdef KEY_EVENT_REPEAT_EN
      pend_repeat  <= (pend_repeat & ~gnt_repeat) | fire_repeat;
`endif
      if (|drop_vec)          overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr         <= rd_next;
      fcnt           <= fcnt_next;
      ev.event_valid <= (fcnt_next != '0);
      // Head register loads the bypassed push when the FIFO would otherwise be empty.
      if (head_from_push) begin
        ev.event_key  <= push_ev.key;
        ev.event_type <= push_ev.kind;
      end else if (fcnt_next != '0) begin
        ev.event_key  <= mem[rd_next].key;
        ev.event_type <= mem[rd_next].kind;
      end
    end
  end
endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: scenario tasks plus a randomized run, checked against an event-level reference model.
module tb_key_event_gen;
  localparam int NK = 8, LONG = 5, REP = 2, DEPTH = 4;
`ifdef KEY_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] key;
    logic [1:0] typ;
  } mev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       overflow_clear = 1'b0;
  logic [7:0] key_in = '0;
  logic       overflow;
  int         vectors = 0;
  int         errors = 0;

  key_event_gen_if #(.KEY_W(3)) ev_if ();

  key_event_gen #(
    .NUM_KEYS(NK), .LONG_PRESS_TICKS(LONG), .REPEAT_TICKS(REP), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick), .key_in(key_in),
    .ev(ev_if), .overflow(overflow), .overflow_clear(overflow_clear)
  );

  always #5 clock = ~clock;

  // Reference model: key down flag, ticks held since press, pending set, event queue.
  bit   m_down [NK];
  int   m_held [NK];
  bit   m_prev [NK];
  bit   m_pend [NK][4];
  mev_t m_q[$];
  bit   m_ovf;
  int   prio [4] = '{0, 2, 3, 1};

  task automatic model_step();
    bit pop, gfound, drop;
    int gk, gt;
    bit fired [NK][4];
    if (!reset) begin
      for (int k = 0; k < NK; k++) begin
        m_down[k] = 0; m_held[k] = 0; m_prev[k] = 0;
        for (int t = 0; t < 4; t++) m_pend[k][t] = 0;
      end
      m_q.delete();
      m_ovf = 0;
      return;
    end
    pop = (m_q.size() > 0) && ev_if.event_ready;
    gfound = 0; gk = 0; gt = 0;
    if (m_q.size() < DEPTH || pop)
      for (int k = 0; k < NK; k++)
        for (int p = 0; p < 4; p++)
          if (!gfound && m_pend[k][prio[p]]) begin gfound = 1; gk = k; gt = prio[p]; end
    for (int k = 0; k < NK; k++) begin
      for (int t = 0; t < 4; t++) fired[k][t] = 0;
      if (!m_down[k]) begin
        if (key_in[k] && !m_prev[k]) begin fired[k][0] = 1; m_down[k] = 1; m_held[k] = 0; end
      end else if (!key_in[k]) begin
        fired[k][1] = 1; m_down[k] = 0;
      end else if (tick) begin
        m_held[k]++;
        if (m_held[k] == LONG) fired[k][2] = 1;
        else if (REP_EN && m_held[k] > LONG && (m_held[k] - LONG) % REP == 0) fired[k][3] = 1;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (gfound) begin
      m_pend[gk][gt] = 0;
      m_q.push_back('{key: 3'(gk), typ: 2'(gt)});
    end
    drop = 0;
    for (int k = 0; k < NK; k++)
      for (int t = 0; t < 4; t++)
        if (fired[k][t]) begin
          if (m_pend[k][t]) drop = 1;
          else m_pend[k][t] = 1;
        end
    if (drop) m_ovf = 1;
    else if (overflow_clear) m_ovf = 0;
    for (int k = 0; k < NK; k++) m_prev[k] = key_in[k];
  endtask

  function automatic logic [6:0] exp_word();
    if (m_q.size() > 0) return {1'b1, m_q[0].key, m_q[0].typ, m_ovf};
    return {1'b0, 3'b0, 2'b0, m_ovf};
  endfunction

  function automatic logic [6:0] got_word();
    return {ev_if.event_valid, ev_if.event_valid ? ev_if.event_key : 3'b0,
            ev_if.event_valid ? ev_if.event_type : 2'b0, overflow};
  endfunction

  task automatic advance();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 0; ev_if.event_ready = 1;
    repeat (2) advance();
    vectors++;
    if ({ev_if.event_valid, overflow} !== 2'b00) begin
      errors++; $display("FAIL reset_state got valid/ovf=%b exp=00", {ev_if.event_valid, overflow});
    end
    reset = 1;
    repeat (2) advance();
    vectors++;
    if (got_word() !== exp_word()) begin
      errors++; $display("FAIL reset_release got=%b exp=%b", got_word(), exp_word());
    end
  endtask

  task automatic test_press();
    logic [5:0] exp_seq [3] = '{6'b0_000_00, 6'b1_011_00, 6'b0_000_00};
    key_in[3] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      advance();
      vectors++;
      if (got_word() !== exp_word() || got_word()[6:1] !== exp_seq[c]) begin
        errors++; $display("FAIL press_latency cyc=%0d got=%b exp=%b", c, got_word(), {exp_seq[c], 1'b0});
      end
    end
  endtask

  task automatic test_hold();
    int long_seen = 0, long_at = 0, rep_seen = 0, rep_mask = 0, rel_seen = 0;
    int exp_rep, exp_mask;
    exp_rep  = REP_EN ? 3 : 0;
    exp_mask = REP_EN ? ((1 << 7) | (1 << 9) | (1 << 11)) : 0;
    for (int i = 1; i <= 12; i++) begin
      for (int s = 0; s < 3; s++) begin
        tick = (s == 0) && (i <= 11);
        if (i == 12 && s == 0) key_in[3] = 1'b0;
        advance();
        tick = 0;
        vectors++;
        if (got_word() !== exp_word()) begin
          errors++; $display("FAIL hold_stream i=%0d got=%b exp=%b", i, got_word(), exp_word());
        end
        if (ev_if.event_valid && ev_if.event_key == 3) begin
          if (ev_if.event_type == 2) begin long_seen++; long_at = i; end
          if (ev_if.event_type == 3) begin rep_seen++; rep_mask |= (1 << i); end
          if (ev_if.event_type == 1) rel_seen++;
        end
      end
    end
    vectors++;
    if (long_seen !== 1 || long_at !== 5) begin
      errors++; $display("FAIL hold_long got count=%0d at_tick=%0d exp count=1 at_tick=5", long_seen, long_at);
    end
    vectors++;
    if (rep_seen !== exp_rep || rep_mask !== exp_mask) begin
      errors++; $display("FAIL hold_repeat got count=%0d mask=%h exp count=%0d mask=%h", rep_seen, rep_mask, exp_rep, exp_mask);
    end
    vectors++;
    if (rel_seen !== 1) begin
      errors++; $display("FAIL hold_release got=%0d exp=1", rel_seen);
    end
  endtask

  task automatic test_simultaneous();
    logic [6:0] exp_seq [4] = '{7'b0_000_00_0, 7'b1_001_00_0, 7'b1_110_00_0, 7'b0_000_00_0};
    key_in = 8'h42;
    for (int c = 0; c < 4; c++) begin
      advance();
      vectors++;
      if (got_word() !== exp_word() || got_word() !== exp_seq[c]) begin
        errors++; $display("FAIL simultaneous cyc=%0d got=%b exp=%b", c, got_word(), exp_seq[c]);
      end
    end
    key_in = 8'h00;
    repeat (5) advance();
  endtask

  task automatic test_release_tick();
    int n_press = 0, n_long = 0, n_rel = 0;
    key_in[2] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick = (c >= 3 && c <= 9 && c % 2 == 1) || (c == 11);
      if (c == 11) key_in[2] = 1'b0;
      advance();
      tick = 0;
      vectors++;
      if (got_word() !== exp_word()) begin
        errors++; $display("FAIL release_tick cyc=%0d got=%b exp=%b", c, got_word(), exp_word());
      end
      if (ev_if.event_valid && ev_if.event_key == 2) begin
        if (ev_if.event_type == 0) n_press++;
        if (ev_if.event_type == 2) n_long++;
        if (ev_if.event_type == 1) n_rel++;
      end
    end
    vectors++;
    if (n_press !== 1 || n_long !== 0 || n_rel !== 1) begin
      errors++; $display("FAIL release_priority got P/L/R=%0d/%0d/%0d exp 1/0/1", n_press, n_long, n_rel);
    end
  endtask

  task automatic test_backpressure();
    int exp_k [6] = '{0, 0, 2, 2, 4, 4};
    int exp_t [6] = '{0, 1, 0, 1, 0, 1};
    int got_k [6], got_t [6];
    int n = 0;
    ev_if.event_ready = 0;
    key_in = 8'h15; advance();
    key_in = 8'h00;
    repeat (6) advance();
    vectors++;
    if (got_word() !== exp_word() || got_word() !== 7'b1_000_00_0) begin
      errors++; $display("FAIL bp_full_head got=%b exp=%b", got_word(), 7'b1_000_00_0);
    end
    ev_if.event_ready = 1;
    for (int c = 0; c < 10; c++) begin
      if (ev_if.event_valid && n < 6) begin got_k[n] = ev_if.event_key; got_t[n] = ev_if.event_type; n++; end
      advance();
      vectors++;
      if (got_word() !== exp_word()) begin
        errors++; $display("FAIL bp_drain cyc=%0d got=%b exp=%b", c, got_word(), exp_word());
      end
    end
    vectors++;
    if (n !== 6) begin errors++; $display("FAIL bp_count got=%0d exp=6", n); end
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (got_k[i] !== exp_k[i] || got_t[i] !== exp_t[i]) begin
        errors++; $display("FAIL bp_order idx=%0d got key=%0d type=%0d exp key=%0d type=%0d",
                           i, got_k[i], got_t[i], exp_k[i], exp_t[i]);
      end
    end
    vectors++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL bp_no_overflow got=%b exp=0", overflow); end

    // Refill, then press key 0 a second time while its PRESS is still pending.
    ev_if.event_ready = 0;
    key_in = 8'h06; advance();
    key_in = 8'h00; repeat (5) advance();
    key_in = 8'h01; advance();
    key_in = 8'h00; advance();
    key_in = 8'h01; advance();
    vectors++;
    if (overflow !== 1'b1 || got_word() !== exp_word()) begin
      errors++; $display("FAIL ovf_set got=%b exp=1 (word %b vs %b)", overflow, got_word(), exp_word());
    end
    key_in = 8'h00; repeat (3) advance();
    vectors++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    overflow_clear = 1; advance(); overflow_clear = 0;
    vectors++;
    if (overflow !== 1'b0 || got_word() !== exp_word()) begin
      errors++; $display("FAIL ovf_clear got=%b exp=0", overflow);
    end
    ev_if.event_ready = 1;
    for (int c = 0; c < 10; c++) begin
      advance();
      vectors++;
      if (got_word() !== exp_word()) begin
        errors++; $display("FAIL ovf_drain cyc=%0d got=%b exp=%b", c, got_word(), exp_word());
      end
    end
  endtask

  task automatic test_reset_mid();
    ev_if.event_ready = 0;
    key_in = 8'h0E;
    repeat (4) advance();
    vectors++;
    if (ev_if.event_valid !== 1'b1 || got_word() !== exp_word()) begin
      errors++; $display("FAIL rst_mid_queued got=%b exp=%b", got_word(), exp_word());
    end
    reset = 0; key_in = 8'h20;
    advance();
    vectors++;
    if ({ev_if.event_valid, overflow} !== 2'b00 || got_word() !== exp_word()) begin
      errors++; $display("FAIL rst_mid_flush got=%b exp=%b", got_word(), 7'b0);
    end
    reset = 1; ev_if.event_ready = 1;
    for (int c = 0; c < 3; c++) begin
      advance();
      vectors++;
      if (got_word() !== exp_word() || got_word() !== ((c == 1) ? 7'b1_101_00_0 : 7'b0)) begin
        errors++; $display("FAIL rst_held_press cyc=%0d got=%b exp=%b", c, got_word(), exp_word());
      end
    end
    key_in = 8'h00;
    repeat (4) advance();
  endtask

  task automatic test_random();
    int pct = 100;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) pct = (c / 250 % 3 == 0) ? 100 : ((c / 250 % 3 == 1) ? 15 : 60);
      for (int k = 0; k < NK; k++) if ($urandom_range(15) == 0) key_in[k] = ~key_in[k];
      tick = ($urandom_range(2) == 0);
      ev_if.event_ready = ($urandom_range(99) < pct);
      overflow_clear = ($urandom_range(31) == 0);
      reset = ($urandom_range(599) != 0);
      advance();
      vectors++;
      if (got_word() !== exp_word()) begin
        errors++; $display("FAIL random cyc=%0d got=%b exp=%b", c, got_word(), exp_word());
      end
    end
    reset = 1; tick = 0; overflow_clear = 0; key_in = 8'h00; ev_if.event_ready = 1;
    for (int c = 0; c < 20; c++) begin
      advance();
      vectors++;
      if (got_word() !== exp_word()) begin
        errors++; $display("FAIL random_drain cyc=%0d got=%b exp=%b", c, got_word(), exp_word());
      end
    end
  endtask

  initial begin
    ev_if.event_ready = 1;
    test_reset();
    test_press();
    test_hold();
    test_simultaneous();
    test_release_tick();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
